nibble_serial_add_ctrl: RTL and testbench

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/adder_ctrl_pkg.sv | 22 ++
 rtl/ripple_carry_adder_4bit.sv | 26 ++
 rtl/nibble_serial_add_ctrl.sv | 142 ++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package adder_ctrl_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Signed overflow of the most significant nibble pass: carry into MSB xor carry out of MSB.
  function automatic logic nibble_overflow(input logic [NIBBLE-1:0] a_nib,
                                           input logic [NIBBLE-1:0] b_nib,
                                           input logic [NIBBLE-1:0] s_nib,
                                           input logic              c_out);
    logic c_into_msb;
    c_into_msb = a_nib[NIBBLE-1] ^ b_nib[NIBBLE-1] ^ s_nib[NIBBLE-1];
    return c_into_msb ^ c_out;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// Combinational 4-bit ripple-carry adder used as the single datapath slice.
module ripple_carry_adder_4bit
  import adder_ctrl_pkg::*;
(
  input  logic [NIBBLE-1:0] a_i,
  input  logic [NIBBLE-1:0] b_i,
  input  logic              cin_i,
  output logic [NIBBLE-1:0] sum_o,
  output logic              cout_o
);

  logic [NIBBLE:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < NIBBLE; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[NIBBLE];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller: one 4-bit pass per cycle over N_NIBBLES nibbles.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_ADD_CTRL_SUBTRACT_EN.
module nibble_serial_add_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned N_NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE*N_NIBBLES-1:0] a,
  input  logic [NIBBLE*N_NIBBLES-1:0] b,
  input  logic                      cin,
  input  logic                      op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE*N_NIBBLES-1:0] sum,
  output logic                      cout,
  output logic                      overflow
);

  localparam int unsigned W     = NIBBLE * N_NIBBLES;
  localparam int unsigned IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBBLES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [W-1:0]      b_load_c;
  logic              c_load_c;
  logic [NIBBLE-1:0] a_nib_c, b_nib_c, s_nib_c;
  logic              c_out_c;

  // Operand conditioning at accept time; subtract is a + ~b + 1.
`ifdef NIBBLE_SERIAL_ADD_CTRL_SUBTRACT_EN
  assign b_load_c = op ? ~b : b;
  assign c_load_c = op ? 1'b1 : cin;
`else
  logic unused_op;
  assign unused_op = op;
  assign b_load_c  = b;
  assign c_load_c  = cin;
`endif

  assign a_nib_c = a_q[idx_q*NIBBLE +: NIBBLE];
  assign b_nib_c = b_q[idx_q*NIBBLE +: NIBBLE];

  ripple_carry_adder_4bit u_rca (
    .a_i    (a_nib_c),
    .b_i    (b_nib_c),
    .cin_i  (carry_q),
    .sum_o  (s_nib_c),
    .cout_o (c_out_c)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_load_c;
          carry_d = c_load_c;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*NIBBLE +: NIBBLE] = s_nib_c;
        carry_d = c_out_c;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = c_out_c;
          ovf_d   = nibble_overflow(a_nib_c, b_nib_c, s_nib_c, c_out_c);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered copies of the upcoming state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl (N_NIBBLES=4).
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin, op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  nibble_serial_add_ctrl #(.N_NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operation, expect out_valid 4 cycles after accept, check result.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_op,
                        input logic tcin, input logic top,
                        input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                        input logic release_it);
    int lat;
    a = ta; b = tb_op; cin = tcin; op = top;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; op = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " sum"}, 32'(sum), 32'(exp_sum));
    check({tag, " cout"}, 32'(cout), 32'(exp_cout));
    check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    if (release_it) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, " released idle"}, 32'({in_ready, out_valid}), 32'b10);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);

    run_op("00FF+0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
    run_op("FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("7FFF+0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    run_op("1234+4321+1", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b1);
    run_op("8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
`ifdef NIBBLE_SERIAL_ADD_CTRL_SUBTRACT_EN
    run_op("5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    run_op("7-5", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
    run_op("7-5 cin ignored", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
`else
    run_op("op ignored 5+7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b1);
`endif

    // Hold in DONE with out_ready low while new operands are offered.
    run_op("hold 1111+2222", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      in_valid = 1'b1;
      step();
      check("hold sum", 32'(sum), 32'h3333);
      check("hold flags", 32'({in_ready, out_valid, cout, overflow}), 32'b0100);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hold released", 32'({in_ready, out_valid}), 32'b10);
    step();
    step();
    check("hold no stray accept", 32'({in_ready, out_valid}), 32'b10);
    check("hold sum after release", 32'(sum), 32'h3333);

    // Reset in the middle of RUN (idx==2).
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; op = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("run in_ready low", 32'(in_ready), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid-run rst idle", 32'({in_ready, out_valid}), 32'b10);
    check("mid-run rst sum", 32'(sum), 32'd0);
    for (int i = 0; i < 6; i++) step();
    check("mid-run rst no result", 32'({in_ready, out_valid}), 32'b10);

    // Reset overrides a simultaneous accept.
    a = 16'h0001; b = 16'h0001;
    in_valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    check("rst beats accept", 32'({in_ready, out_valid}), 32'b10);

    run_op("0F0F+00F1", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
